// File: rtl/perceptron_trainer.sv
`default_nettype none
// ============================================================================
// perceptron_trainer : steps stored samples through an external perceptron and
//                      counts mismatches per epoch until convergence or limit.
// Rev 1.0
// ============================================================================
module perceptron_trainer #(
   parameter int NUM_SAMPLES = 8,
   parameter int LATENCY     = 2,
   parameter int MAX_EPOCHS  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       start,
   input  logic [7:0] thr_in,
   input  logic [1:0] result,
   output logic [6:0] p_in,
   output logic [7:0] threshold,
   output logic       exp_res,
   output logic       busy,
   output logic       done,
   output logic       converged,
   output logic [3:0] epoch_count,
   output logic [3:0] err_count
);

   localparam int            c_IW          = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
   localparam int            c_WW          = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(NUM_SAMPLES - 1);
   localparam logic [c_WW-1:0] c_LAST_WAIT = c_WW'(LATENCY - 1);
   localparam logic [3:0]    c_MAX_EPOCHS  = 4'(MAX_EPOCHS);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DRIVE     = 3'd1,
      S_WAIT      = 3'd2,
      S_CHECK     = 3'd3,
      S_EPOCH_END = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t          r_state;
   logic [7:0]      r_mem [NUM_SAMPLES];
   logic [c_IW-1:0] r_idx;
   logic [c_WW-1:0] r_wait;
   logic [6:0]      r_p_in;
   logic            r_exp_res;
   logic [7:0]      r_thr;
   logic            r_busy;
   logic            r_done;
   logic            r_conv;
   logic [3:0]      r_epoch;
   logic [3:0]      r_err;

   logic [c_IW-1:0] w_wr_idx;
   logic [1:0]      w_expected;
   logic            w_mismatch;
   logic [3:0]      w_epoch_next;

   assign w_wr_idx     = wr_addr[c_IW-1:0];
   assign w_expected   = r_exp_res ? 2'b01 : 2'b11;
   assign w_mismatch   = (result != w_expected);
   assign w_epoch_next = r_epoch + 4'd1;

   // Sample memory is frozen while a run is in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SAMPLES; i++) r_mem[i] <= '0;
      end else if (wr_en && !r_busy) begin
         r_mem[w_wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_wait    <= '0;
         r_p_in    <= '0;
         r_exp_res <= 1'b0;
         r_thr     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_conv    <= 1'b0;
         r_epoch   <= '0;
         r_err     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_thr   <= thr_in;
                  r_idx   <= '0;
                  r_err   <= '0;
                  r_epoch <= '0;
                  r_conv  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               r_p_in    <= r_mem[r_idx][6:0];
               r_exp_res <= r_mem[r_idx][7];
               r_wait    <= '0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wait == c_LAST_WAIT) r_state <= S_CHECK;
               else                       r_wait  <= r_wait + 1'b1;
            end
            S_CHECK: begin
               if (w_mismatch && (r_err != 4'hF)) r_err <= r_err + 4'd1;
               if (r_idx == c_LAST_IDX) begin
                  r_state <= S_EPOCH_END;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_DRIVE;
               end
            end
            S_EPOCH_END: begin
               r_epoch <= w_epoch_next;
               if (r_err == 4'd0) begin
                  r_conv  <= 1'b1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else if (w_epoch_next == c_MAX_EPOCHS) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_err   <= '0;
                  r_idx   <= '0;
                  r_state <= S_DRIVE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign p_in        = r_p_in;
   assign threshold   = r_thr;
   assign exp_res     = r_exp_res;
   assign busy        = r_busy;
   assign done        = r_done;
   assign converged   = r_conv;
   assign epoch_count = r_epoch;
   assign err_count   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_trainer.sv
`default_nettype none
// Bench for perceptron_trainer: table of training runs scored against queued
// expectations, plus reset, busy-disturbance and back-to-back start sequences.
module tb_perceptron_trainer;
   localparam int NS   = 8;
   localparam int LAT  = 2;
   localparam int MAXE = 15;
   localparam int SP   = LAT + 2;
   localparam int EP   = NS * SP + 1;

   logic       clk = 1'b0;
   logic       reset, wr_en, start, exp_res, busy, done, converged;
   logic [2:0] wr_addr;
   logic [7:0] wr_data, thr_in, threshold;
   logic [1:0] result;
   logic [6:0] p_in;
   logic [3:0] epoch_count, err_count;

   int tests = 0;
   int fails = 0;
   logic [7:0] mem_m [NS];

   typedef struct {
      int         mode;
      logic [7:0] thr;
      int         epochs;
      logic       conv;
      int         errs;
   } run_t;

   typedef struct {
      int         epochs;
      logic       conv;
      int         errs;
      logic [7:0] thr;
   } outcome_t;

   logic [7:0] sample_q [$];
   outcome_t   outcome_q [$];
   run_t       runs [4];
   run_t       rr;

   perceptron_trainer #(.NUM_SAMPLES(NS), .LATENCY(LAT), .MAX_EPOCHS(MAXE)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .thr_in(thr_in), .result(result), .p_in(p_in),
      .threshold(threshold), .exp_res(exp_res), .busy(busy), .done(done),
      .converged(converged), .epoch_count(epoch_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Perceptron stand-in: mode 0 correct, 1 invalid code, 2 wrong on sample 3 of epoch 1, 3 always -1.
   function automatic logic [1:0] model(input int mode, input int e, input int s);
      logic [1:0] good;
      if (s >= NS) return 2'b00;
      good = mem_m[s][7] ? 2'b01 : 2'b11;
      case (mode)
         0:       return good;
         1:       return 2'b00;
         2:       return (e == 0 && s == 3) ? ~good : good;
         default: return 2'b11;
      endcase
   endfunction

   task automatic write_mem(input int a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic run(input run_t r, input bit disturb, input bit sim_wr);
      outcome_t   o;
      bit         early;
      int         e, off, s, ph, exp_k;
      logic [7:0] cur;
      if (sim_wr) begin
         wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hA5; mem_m[0] = 8'hA5;
      end
      for (int i = 0; i < NS; i++) sample_q.push_back(mem_m[i]);
      o.epochs = r.epochs; o.conv = r.conv; o.errs = r.errs; o.thr = r.thr;
      outcome_q.push_back(o);
      exp_k = r.epochs * EP;
      start = 1'b1; thr_in = r.thr;
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0; thr_in = 8'h00;
      early = 1'b0; cur = '0;
      for (int k = 1; k <= exp_k; k++) begin
         @(posedge clk); #1;
         e   = (k - 1) / EP;
         off = (k - 1) % EP;
         s   = off / SP;
         ph  = off % SP;
         result = model(r.mode, e, s);
         if (k == 1) check("busy_run", busy, 1);
         if (disturb && k == 5) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; start = 1'b1; thr_in = 8'h99;
         end
         if (disturb && k == 6) begin
            wr_en = 1'b0; start = 1'b0; thr_in = 8'h00;
         end
         if (e == 0 && s < NS) begin
            if (ph == 0) cur = sample_q.pop_front();
            check("p_in", p_in, cur[6:0]);
            check("exp_res", exp_res, cur[7]);
         end
         if (k < exp_k && done) early = 1'b1;
      end
      check("no_early_done", early, 0);
      o = outcome_q.pop_front();
      check("done", done, 1);
      check("epoch_count", epoch_count, o.epochs);
      check("converged", converged, o.conv);
      check("err_count", err_count, o.errs);
      check("threshold", threshold, o.thr);
      check("busy_done", busy, 0);
   endtask

   initial begin
      logic [7:0] d;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; thr_in = '0; result = 2'b00;
      for (int i = 0; i < NS; i++) mem_m[i] = '0;
      runs[0] = '{0, 8'h40, 1,    1'b1, 0};
      runs[1] = '{1, 8'h12, MAXE, 1'b0, NS};
      runs[2] = '{2, 8'h7F, 2,    1'b1, 0};
      runs[3] = '{3, 8'hC3, MAXE, 1'b0, NS / 2};

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_p_in", p_in, 0);
      check("rst_thr", threshold, 0);
      check("rst_epoch", epoch_count, 0);
      check("rst_err", err_count, 0);
      check("rst_conv", converged, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NS; i++) begin
         d[7]   = (i % 2) == 1;
         d[6:0] = 7'(19 + 17 * i);
         write_mem(i, d);
      end

      // Back-to-back runs: each start lands in the cycle of the previous done pulse.
      for (int t = 0; t < 4; t++) run(runs[t], 1'b0, 1'b0);

      rr = '{0, 8'h40, 1, 1'b1, 0};
      run(rr, 1'b1, 1'b0);
      run(runs[0], 1'b0, 1'b0);

      @(posedge clk); #1;
      check("done_pulse_width", done, 0);
      check("hold_epoch", epoch_count, 1);
      check("hold_conv", converged, 1);
      check("hold_p_in", p_in, mem_m[NS-1][6:0]);

      // Reset asserted mid-WAIT.
      start = 1'b1; thr_in = 8'h55;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_p_in", p_in, 0);
      check("midrst_epoch", epoch_count, 0);
      check("midrst_thr", threshold, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < NS; i++) mem_m[i] = '0;
      repeat (3) begin
         @(posedge clk); #1;
         check("post_rst_done", done, 0);
         check("post_rst_busy", busy, 0);
      end

      // Write with start in IDLE; remaining entries must read back cleared.
      rr = '{0, 8'h21, 1, 1'b1, 0};
      run(rr, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
